// File: rtl/ble_button_parser_if.sv
// rtl/ble_button_parser_if.sv - received UART byte stream bundle
//
// Purpose: carries one received byte plus its single-cycle strobe from the
// UART receiver (master) to the button parser (slave).
// Signals:
//   byte_in        8  received byte, meaningful only while byte_valid_in is high
//   byte_valid_in  1  one-cycle strobe per received byte
interface ble_button_parser_if;
  logic [7:0] byte_in;
  logic       byte_valid_in;

  modport master (output byte_in, output byte_valid_in);
  modport slave  (input  byte_in, input  byte_valid_in);
endinterface

// File: rtl/ble_button_parser.sv
// rtl/ble_button_parser.sv - Bluefruit button packet parser with held button levels
//
// Purpose: parses "!B<n><s><csum>" controller packets from the BLE UART byte
// stream, verifies the checksum and keeps a held pressed/released level per
// button. Malformed, mis-summed or stalled packets are dropped and flagged.
// Ports:
//   clk_in            1  system clock
//   rst_in            1  asynchronous active-high reset
//   rx                   byte stream (slave modport): byte_in[7:0], byte_valid_in
//   btn_state_out     8  held levels of buttons 1..8 (bit 0 = button 1)
//   hit_out           1  button 1 level
//   pan_left_out      1  button 7 level
//   pan_right_out     1  button 8 level
//   last_btn_out      4  number of the last accepted button, 0 before the first
//   pkt_valid_out     1  one-cycle pulse per accepted packet
//   pkt_err_out       1  one-cycle pulse per rejected or timed-out packet
module ble_button_parser #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  ble_button_parser_if.slave         rx,
  output logic [7:0]                 btn_state_out,
  output logic                       hit_out,
  output logic                       pan_left_out,
  output logic                       pan_right_out,
  output logic [3:0]                 last_btn_out,
  output logic                       pkt_valid_out,
  output logic                       pkt_err_out
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_B    = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_NUM,
    S_STATE,
    S_CSUM
  } state_t;

  state_t        state_q;
  logic [7:0]    sum_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;      // zero-based button index (button n -> n-1)
  logic          level_q;
  logic [7:0]    btn_q;
  logic [3:0]    last_q;
  logic          valid_q;
  logic          err_q;

  logic [7:0] byte_w;
  logic       bv_w;
  logic [7:0] sum_d;
  logic       is_digit_w;
  logic       is_level_w;

  assign byte_w     = rx.byte_in;
  assign bv_w       = rx.byte_valid_in;
  assign sum_d      = sum_q + byte_w;
  assign is_digit_w = (byte_w >= 8'h31) && (byte_w <= 8'h38);
  assign is_level_w = (byte_w == 8'h30) || (byte_w == 8'h31);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      sum_q   <= 8'h00;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      level_q <= 1'b0;
      btn_q   <= 8'h00;
      last_q  <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (bv_w) begin
        // A byte always wins over a timeout landing on the same cycle.
        cnt_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (byte_w == CH_BANG) begin
              state_q <= S_TYPE;
              sum_q   <= CH_BANG;
            end
          end
          S_TYPE, S_NUM, S_STATE: begin
            if ((state_q == S_TYPE  && byte_w == CH_B) ||
                (state_q == S_NUM   && is_digit_w)     ||
                (state_q == S_STATE && is_level_w)) begin
              sum_q <= sum_d;
              if (state_q == S_TYPE) begin
                state_q <= S_NUM;
              end else if (state_q == S_NUM) begin
                state_q <= S_STATE;
                // '1'..'8' low bits are 1..7,0; minus one gives 0..7.
                idx_q   <= byte_w[2:0] - 3'd1;
              end else begin
                state_q <= S_CSUM;
                level_q <= byte_w[0];
              end
            end else begin
              err_q <= 1'b1;
              // A stray '!' is taken as the start of a fresh packet.
              if (byte_w == CH_BANG) begin
                state_q <= S_TYPE;
                sum_q   <= CH_BANG;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_CSUM: begin
            if (byte_w == ~sum_q) begin
              btn_q[idx_q] <= level_q;
              last_q       <= 4'(idx_q) + 4'd1;
              valid_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (cnt_q == CNT_LAST) begin
          err_q   <= 1'b1;
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign btn_state_out = btn_q;
  assign hit_out       = btn_q[0];
  assign pan_left_out  = btn_q[6];
  assign pan_right_out = btn_q[7];
  assign last_btn_out  = last_q;
  assign pkt_valid_out = valid_q;
  assign pkt_err_out   = err_q;

endmodule

// File: tb/tb_ble_button_parser.sv
// tb/tb_ble_button_parser.sv - directed self-checking bench for ble_button_parser
module tb_ble_button_parser;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] btn_state_out;
  logic       hit_out;
  logic       pan_left_out;
  logic       pan_right_out;
  logic [3:0] last_btn_out;
  logic       pkt_valid_out;
  logic       pkt_err_out;

  ble_button_parser_if rx ();

  ble_button_parser #(.TIMEOUT_CYCLES(50)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rx            (rx),
    .btn_state_out (btn_state_out),
    .hit_out       (hit_out),
    .pan_left_out  (pan_left_out),
    .pan_right_out (pan_right_out),
    .last_btn_out  (last_btn_out),
    .pkt_valid_out (pkt_valid_out),
    .pkt_err_out   (pkt_err_out)
  );

  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;

  // Pulses last one cycle, so each is seen exactly once at a falling edge.
  always @(negedge clk_in) begin
    if (pkt_valid_out === 1'b1) n_valid++;
    if (pkt_err_out === 1'b1) n_err++;
    if (pkt_valid_out === 1'b1 && pkt_err_out === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    rx.byte_in = b;
    rx.byte_valid_in = 1'b1;
    @(negedge clk_in);
    rx.byte_valid_in = 1'b0;
    rx.byte_in = 8'h00;
  endtask

  // Back-to-back bytes: each strobe directly follows the previous one.
  task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input int n);
    logic [7:0] v [5];
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3; v[4] = b4;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      rx.byte_in = v[k];
      rx.byte_valid_in = 1'b1;
    end
    @(negedge clk_in);
    rx.byte_valid_in = 1'b0;
    rx.byte_in = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  int v0, e0, err_at;

  initial begin
    rx.byte_in = 8'h00;
    rx.byte_valid_in = 1'b0;
    idle(3);
    @(negedge clk_in) rst_in = 1'b0;
    idle(2);

    // Reset state
    check("rst_btn",   btn_state_out, 8'h00);
    check("rst_last",  last_btn_out, 4'd0);
    check("rst_valid", pkt_valid_out, 1'b0);
    check("rst_err",   pkt_err_out, 1'b0);

    // Press button 1, then release it
    v0 = n_valid; e0 = n_err;
    send_seq(8'h21, 8'h42, 8'h31, 8'h31, 8'h3A, 5);
    idle(2);
    check("press_valid_cnt", n_valid - v0, 1);
    check("press_err_cnt",   n_err - e0, 0);
    check("press_hit",       hit_out, 1'b1);
    check("press_btn",       btn_state_out, 8'h01);
    check("press_last",      last_btn_out, 4'd1);
    send_seq(8'h21, 8'h42, 8'h31, 8'h30, 8'h3B, 5);
    idle(2);
    check("release_hit", hit_out, 1'b0);
    check("release_valid_cnt", n_valid - v0, 2);

    // Both arrows held together
    send_seq(8'h21, 8'h42, 8'h37, 8'h31, 8'h34, 5);
    send_seq(8'h21, 8'h42, 8'h38, 8'h31, 8'h33, 5);
    idle(2);
    check("arrow_left",  pan_left_out, 1'b1);
    check("arrow_right", pan_right_out, 1'b1);
    check("arrow_btn",   btn_state_out, 8'hC0);
    check("arrow_last",  last_btn_out, 4'd8);

    // Release both arrows
    send_seq(8'h21, 8'h42, 8'h37, 8'h30, 8'h35, 5);
    send_seq(8'h21, 8'h42, 8'h38, 8'h30, 8'h34, 5);
    idle(2);
    check("arrow_rel_btn", btn_state_out, 8'h00);

    // Bad checksum
    v0 = n_valid; e0 = n_err;
    send_seq(8'h21, 8'h42, 8'h31, 8'h31, 8'h00, 5);
    idle(2);
    check("badcs_err_cnt",   n_err - e0, 1);
    check("badcs_valid_cnt", n_valid - v0, 0);
    check("badcs_btn",       btn_state_out, 8'h00);
    check("badcs_last",      last_btn_out, 4'd8);

    // Resync on a stray '!' in the middle of a packet
    v0 = n_valid; e0 = n_err;
    send_seq(8'h21, 8'h42, 8'h21, 8'h42, 8'h31, 5);
    send_seq(8'h31, 8'h3A, 8'h00, 8'h00, 8'h00, 2);
    idle(2);
    check("resync_err_cnt",   n_err - e0, 1);
    check("resync_valid_cnt", n_valid - v0, 1);
    check("resync_hit",       hit_out, 1'b1);

    // Junk in IDLE is silent
    v0 = n_valid; e0 = n_err;
    send_seq(8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 2);
    idle(3);
    check("junk_err_cnt",   n_err - e0, 0);
    check("junk_valid_cnt", n_valid - v0, 0);

    // Timeout after a partial packet
    e0 = n_err;
    err_at = -1;
    send_seq(8'h21, 8'h42, 8'h00, 8'h00, 8'h00, 2);
    for (int i = 0; i < 60; i++) begin
      if (pkt_err_out === 1'b1 && err_at < 0) err_at = i;
      @(negedge clk_in);
    end
    check("timeout_err_cnt", n_err - e0, 1);
    check("timeout_when", (err_at >= 48 && err_at <= 50), 1'b1);
    v0 = n_valid;
    send_seq(8'h21, 8'h42, 8'h31, 8'h31, 8'h3A, 5);
    idle(2);
    check("after_to_valid_cnt", n_valid - v0, 1);

    // Async reset mid-packet with a button held
    send_seq(8'h21, 8'h42, 8'h31, 8'h00, 8'h00, 3);
    check("pre_rst_hit", hit_out, 1'b1);
    rst_in = 1'b1;
    #1;
    check("async_rst_btn",  btn_state_out, 8'h00);
    check("async_rst_hit",  hit_out, 1'b0);
    check("async_rst_last", last_btn_out, 4'd0);
    @(negedge clk_in) rst_in = 1'b0;
    v0 = n_valid; e0 = n_err;
    send_seq(8'h31, 8'h3A, 8'h00, 8'h00, 8'h00, 2);
    idle(3);
    check("post_rst_valid_cnt", n_valid - v0, 0);
    check("post_rst_err_cnt",   n_err - e0, 0);
    check("post_rst_btn",       btn_state_out, 8'h00);

    check("never_both", n_both, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
